serial_add_ctrl: RTL and testbench

//   Bit-serial N-bit adder controller built around one full_adder cell.

---
 rtl/serial_add_ctrl.sv | 150 +++++++++++++++
 tb/tb_serial_add_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one shared full_adder cell processes the operands
// LSB first, one bit per cycle, with the carry held in a register between bits.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);
  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             c_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] s_sh_r;
  logic [WIDTH-1:0] s_shift_s;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic             load_s;
  logic             last_bit_s;
  logic             fa_sum_s;
  logic             fa_cout_s;
  logic             ready_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             c_out_r;

  full_adder u_fa (
    .a     (a_sh_r[0]),
    .b     (b_sh_r[0]),
    .c_in  (carry_r),
    .s     (fa_sum_s),
    .c_out (fa_cout_s)
  );

  // Next-state decode plus accept/last-bit strobes for the datapath.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    last_bit_s   = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_next_s = RUN;
          load_s       = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CNT_LAST) begin
          state_next_s = DONE;
          last_bit_s   = 1'b1;
        end else begin
          state_next_s = RUN;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Sum shift register with the freshly computed bit entering at the MSB.
  always_comb begin
    s_shift_s            = s_sh_r >> 1'b1;
    s_shift_s[WIDTH-1]   = fa_sum_s;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand/sum shifters, carry, bit counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      s_sh_r  <= '0;
      carry_r <= 1'b0;
      cnt_r   <= CNT_ZERO;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      sum_r   <= '0;
      c_out_r <= 1'b0;
    end else begin
      ready_r <= (state_next_s == IDLE) || (state_next_s == DONE);
      busy_r  <= (state_next_s == RUN);
      done_r  <= last_bit_s;
      if (load_s) begin
        a_sh_r  <= op_a;
        b_sh_r  <= op_b;
        carry_r <= c_in;
        cnt_r   <= CNT_ZERO;
      end else if (state_r == RUN) begin
        a_sh_r  <= a_sh_r >> 1'b1;
        b_sh_r  <= b_sh_r >> 1'b1;
        s_sh_r  <= s_shift_s;
        carry_r <= fa_cout_s;
        cnt_r   <= cnt_r + CNT_ONE;
        // The final bit is folded in here so sum is valid in the done cycle.
        if (last_bit_s) begin
          sum_r   <= s_shift_s;
          c_out_r <= fa_cout_s;
        end
      end
    end
  end

  assign ready = ready_r;
  assign busy  = busy_r;
  assign done  = done_r;
  assign sum   = sum_r;
  assign c_out = c_out_r;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: accepted starts push the arithmetic
// reference result, a negedge monitor pops and compares on every done pulse.

module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         c_in;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_accepted = 0;
  int n_done = 0;
  logic [W:0] exp_q[$];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .c_in(c_in),
    .ready(ready), .busy(busy), .done(done), .sum(sum), .c_out(c_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check("result", {c_out, sum}, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!ready && k < 50) begin
      tick();
      k++;
    end
    if (!ready) check("ready_timeout", 0, 1);
  endtask

  // Drive one request; returns 1 time unit after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    wait_ready();
    start = 1'b1;
    op_a = a;
    op_b = b;
    c_in = c;
    exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, c});
    n_accepted++;
    tick();
    start = 1'b0;
    op_a = W'($urandom);
    op_b = W'($urandom);
    c_in = 1'($urandom);
  endtask

  initial begin
    int busy_cycles;
    int lat;
    logic [W-1:0] held;
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; c_in = 1'b0;
    tick(); tick();
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", c_out, 0);
    rst = 1'b0;
    tick();

    // Directed: latency and busy window.
    issue(8'h5A, 8'h3C, 1'b0);
    busy_cycles = 0;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      if (busy) busy_cycles++;
      if (done && lat == 0) lat = k;
      tick();
    end
    check("busy_cycles", busy_cycles, 8);
    check("done_latency", lat, 9);
    check("sum_5a_3c", sum, 8'h96);

    issue(8'hFF, 8'h01, 1'b0);
    wait_ready();
    issue(8'hFF, 8'hFF, 1'b1);
    wait_ready();
    tick();

    // Start held into RUN with changing operands must be ignored.
    issue(8'h12, 8'h34, 1'b1);
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      op_a = W'($urandom);
      tick();
    end
    start = 1'b0;
    wait_ready();
    tick();
    check("held_start_result", sum, 8'h47);

    // Start accepted in the DONE cycle; prior sum held until next done.
    issue(8'h44, 8'h11, 1'b0);
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    check("done_seen", done, 1);
    held = sum;
    check("prior_sum", held, 8'h55);
    issue(8'h10, 8'h20, 1'b0);
    lat = 1;
    while (!done && lat < 20) begin
      check("sum_held", sum, 8'h55);
      tick();
      lat++;
    end
    check("b2b_latency", lat, 9);
    check("b2b_sum", sum, 8'h30);
    tick();

    // Reset during RUN aborts the operation.
    issue(8'hA5, 8'h5A, 1'b1);
    tick(); tick(); tick();
    rst = 1'b1;
    exp_q.delete();
    n_accepted--;
    tick();
    rst = 1'b0;
    check("abort_ready", ready, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", c_out, 0);
    for (int k = 0; k < 12; k++) tick();
    issue(8'h80, 8'h80, 1'b1);

    // Random traffic with 0..3 idle cycles between requests.
    for (int i = 0; i < 1000; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      wait_ready();
      for (int g = 0; g < gap; g++) tick();
      issue(W'($urandom), W'($urandom), 1'($urandom));
    end

    lat = 0;
    while (exp_q.size() != 0 && lat < 50) begin
      tick();
      lat++;
    end
    tick(); tick();
    check("queue_drained", exp_q.size(), 0);
    check("done_count", n_done, n_accepted);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
